// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma UART scheduler.
// ENIGMA_LOWERCASE_EN folds 'a'..'z' onto their capitals.
package enigma_pkg;

    localparam logic [7:0] ASCII_A  = 8'd65;
    localparam logic [7:0] ALPHABET = 8'd26;
    localparam logic [7:0] CFG_MARK = 8'h23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CORE,
        ST_WAIT_TX,
        ST_SEND,
        ST_HOLD,
        ST_CFG
    } state_t;

    typedef enum logic {
        PS_IDLE,
        PS_CFG
    } pstate_t;

    typedef struct packed {
        logic        is_cfg;
        logic [14:0] payload;
    } fifo_entry_t;

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef ENIGMA_LOWERCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

endpackage

// File: rtl/fifo_sincron.sv
// Generic synchronous show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted only alongside a pop.
module fifo_sincron #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && (!o_full || i_pop);
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_rd) r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/planificator_enigma.sv
// UART-to-Enigma scheduler: parses letters/'#LMR' configs into one FIFO.
// ENIGMA_LOWERCASE_EN accepts lowercase input as capitals.
module planificator_enigma
    import enigma_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic        core_valid_in,
    output logic [4:0]  core_char_in,
    input  logic [4:0]  core_char_out,
    input  logic        core_valid_out,
    output logic        core_cfg_we,
    output logic [14:0] core_cfg_pos,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic [4:0]  fifo_count,
    output logic        err_flag
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]  w_ch;
    logic [7:0]  w_diff;
    logic        w_cap;
    logic [4:0]  w_idx;

    pstate_t     r_ps;
    logic [1:0]  r_cnt;
    logic [4:0]  r_l;
    logic [4:0]  r_m;
    logic        r_push;
    fifo_entry_t r_push_d;

    fifo_entry_t w_head;
    logic [15:0] w_fifo_q;
    logic [CW-1:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_ovf;

    state_t      r_st;
    logic [TW-1:0] r_tmo;
    logic [4:0]  r_res;
    logic        r_valid_in;
    logic [4:0]  r_char_in;
    logic        r_cfg_we;
    logic [14:0] r_cfg_pos;
    logic        r_tx_start;
    logic [7:0]  r_tx_byte;
    logic        r_err;

    // Below 'A' wraps high, so one compare classifies capitals.
    assign w_ch   = fold_case(rx_byte);
    assign w_diff = w_ch - ASCII_A;
    assign w_cap  = (w_diff < ALPHABET);
    assign w_idx  = w_diff[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps     <= PS_IDLE;
            r_cnt    <= '0;
            r_l      <= '0;
            r_m      <= '0;
            r_push   <= 1'b0;
            r_push_d <= '0;
        end else begin
            r_push <= 1'b0;
            if (rx_done) begin
                if (w_ch == CFG_MARK) begin
                    r_ps  <= PS_CFG;
                    r_cnt <= '0;
                end else if (r_ps == PS_CFG) begin
                    if (!w_cap) begin
                        r_ps <= PS_IDLE;
                    end else begin
                        unique case (r_cnt)
                            2'd0: begin
                                r_l   <= w_idx;
                                r_cnt <= 2'd1;
                            end
                            2'd1: begin
                                r_m   <= w_idx;
                                r_cnt <= 2'd2;
                            end
                            default: begin
                                r_push   <= 1'b1;
                                r_push_d <= '{is_cfg: 1'b1,
                                              payload: {r_l, r_m, w_idx}};
                                r_ps     <= PS_IDLE;
                            end
                        endcase
                    end
                end else if (w_cap) begin
                    r_push   <= 1'b1;
                    r_push_d <= '{is_cfg: 1'b0,
                                  payload: {10'd0, w_idx}};
                end
            end
        end
    end

    fifo_sincron #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_push_d),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head = w_fifo_q;
    assign w_pop  = (r_st == ST_IDLE) && !w_empty &&
                    (w_head.is_cfg || !tx_busy);
    assign w_ovf  = r_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= ST_IDLE;
            r_tmo      <= '0;
            r_res      <= '0;
            r_valid_in <= 1'b0;
            r_char_in  <= '0;
            r_cfg_we   <= 1'b0;
            r_cfg_pos  <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_valid_in <= 1'b0;
            r_cfg_we   <= 1'b0;
            r_tx_start <= 1'b0;
            if (w_ovf) r_err <= 1'b1;
            unique case (r_st)
                ST_IDLE: begin
                    if (w_pop && w_head.is_cfg) begin
                        r_st      <= ST_CFG;
                        r_cfg_we  <= 1'b1;
                        r_cfg_pos <= w_head.payload;
                    end else if (w_pop) begin
                        r_st       <= ST_ISSUE;
                        r_valid_in <= 1'b1;
                        r_char_in  <= w_head.payload[4:0];
                    end
                end
                ST_ISSUE: begin
                    r_st  <= ST_WAIT_CORE;
                    r_tmo <= '0;
                end
                ST_WAIT_CORE: begin
                    if (core_valid_out) begin
                        r_res <= core_char_out;
                        r_st  <= ST_WAIT_TX;
                    end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                        r_err <= 1'b1;
                        r_tmo <= '0;
                        r_st  <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WAIT_TX: begin
                    if (!tx_busy) begin
                        r_st       <= ST_SEND;
                        r_tx_start <= 1'b1;
                        r_tx_byte  <= {3'b000, r_res} + ASCII_A;
                    end
                end
                ST_SEND: r_st <= ST_HOLD;
                ST_HOLD: r_st <= ST_IDLE;
                ST_CFG:  r_st <= ST_IDLE;
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    assign core_valid_in = r_valid_in;
    assign core_char_in  = r_char_in;
    assign core_cfg_we   = r_cfg_we;
    assign core_cfg_pos  = r_cfg_pos;
    assign tx_start      = r_tx_start;
    assign tx_byte       = r_tx_byte;
    assign err_flag      = r_err;
    assign fifo_count    = 5'(w_count);

endmodule

// File: tb/tb_planificator_enigma.sv
// Scoreboard bench for planificator_enigma with a +3 core model
// and a 10-cycle busy UART model.
module tb_planificator_enigma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_done = 1'b0;
    logic        core_valid_in;
    logic [4:0]  core_char_in;
    logic [4:0]  core_char_out = '0;
    logic        core_valid_out = 1'b0;
    logic        core_cfg_we;
    logic [14:0] core_cfg_pos;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic [4:0]  fifo_count;
    logic        err_flag;

    always #5 clk = ~clk;

    planificator_enigma #(
        .FIFO_DEPTH  (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_byte        (rx_byte),
        .rx_done        (rx_done),
        .core_valid_in  (core_valid_in),
        .core_char_in   (core_char_in),
        .core_char_out  (core_char_out),
        .core_valid_out (core_valid_out),
        .core_cfg_we    (core_cfg_we),
        .core_cfg_pos   (core_cfg_pos),
        .tx_start       (tx_start),
        .tx_byte        (tx_byte),
        .tx_busy        (tx_busy),
        .fifo_count     (fifo_count),
        .err_flag       (err_flag)
    );

    typedef struct {
        bit is_cfg;
        int val;
    } ev_t;

    ev_t ev_q[$];
    int  tx_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  issue_cyc = 0;
    bit  lat_arm = 0;
    bit  core_en = 1;
    bit  force_busy = 0;
    int  busy_cnt = 0;
    bit  p1 = 0;
    logic [4:0] d1 = '0;
    ev_t e;
    int  t;

    assign tx_busy = force_busy || (busy_cnt != 0);

    // Core answers two edges after issue with (x+3) mod 26.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        p1 <= core_valid_in && core_en;
        d1 <= 5'((int'(core_char_in) + 3) % 26);
        core_valid_out <= p1;
        core_char_out <= d1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_cfg_we) begin
                chk("cfg_expected", int'(ev_q.size() > 0), 1);
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    chk("cfg_order", int'(e.is_cfg), 1);
                    chk("cfg_pos", int'(core_cfg_pos), e.val);
                end
            end
            if (core_valid_in) begin
                issue_cyc = cyc;
                chk("issue_expected", int'(ev_q.size() > 0), 1);
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    chk("issue_order", int'(e.is_cfg), 0);
                    chk("issue_char", int'(core_char_in), e.val);
                end
            end
            if (tx_start) begin
                chk("tx_expected", int'(tx_q.size() > 0), 1);
                chk("tx_overlap_busy", int'(tx_busy), 0);
                if (tx_q.size() > 0) begin
                    t = tx_q.pop_front();
                    chk("tx_byte", int'(tx_byte), t);
                end
                if (lat_arm) begin
                    chk("issue_to_tx_latency", cyc - issue_cyc, 4);
                    lat_arm = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic exp_issue(input int idx, input bit with_tx);
        ev_q.push_back('{1'b0, idx});
        if (with_tx) tx_q.push_back((idx + 3) % 26 + 65);
    endtask

    task automatic exp_cfg(input int l, input int m, input int r);
        ev_q.push_back('{1'b1, (l << 10) | (m << 5) | r});
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 2000; k++) begin
            if (ev_q.size() == 0 && tx_q.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, ev_q.size() + tx_q.size(), 0);
        repeat (15) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_err", int'(err_flag), 0);
        chk("rst_tx_byte", int'(tx_byte), 0);
        chk("rst_cfg_pos", int'(core_cfg_pos), 0);
        chk("rst_char_in", int'(core_char_in), 0);
        chk("rst_strobes", int'({tx_start, core_valid_in, core_cfg_we}), 0);
        rst_n = 1'b1;

        // Two letters, core 2-cycle, UART busy 10 cycles each.
        lat_arm = 1;
        exp_issue(7, 1);
        exp_issue(8, 1);
        send("H");
        send("I");
        drain("drain_HI");

        // Config then letter, strictly ordered.
        exp_cfg(0, 1, 2);
        exp_issue(23, 1);
        send_str("#ABCX");
        drain("drain_cfg");
        chk("cfg_pos_held", int'(core_cfg_pos), 34);

        // Aborted config, then letter.
        exp_issue(16, 1);
        send_str("#A1Q");
        drain("drain_abort");
        chk("abort_no_err", int'(err_flag), 0);

        // Second '#' restarts collection.
        exp_cfg(1, 2, 3);
        exp_issue(4, 1);
        send_str("#A#BCDE");
        drain("drain_restart");
        chk("restart_cfg_pos", int'(core_cfg_pos), (1 << 10) | (2 << 5) | 3);

        // Lowercase handling depends on build option.
`ifdef ENIGMA_LOWERCASE_EN
        exp_issue(0, 1);
`endif
        send("a");
        drain("drain_lower");
        chk("lower_no_err", int'(err_flag), 0);

        // Overflow: nine letters with UART held busy.
        force_busy = 1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_issue(i, 1);
            send(8'(65 + i));
        end
        repeat (3) @(negedge clk);
        chk("ovf_fifo_count", int'(fifo_count), 8);
        chk("ovf_err", int'(err_flag), 1);
        force_busy = 0;
        drain("drain_ovf");
        chk("ovf_fifo_empty", int'(fifo_count), 0);

        do_reset();
        chk("reset_clears_err", int'(err_flag), 0);

        // Core timeout, then recovery.
        core_en = 0;
        exp_issue(2, 0);
        send("C");
        repeat (30) @(negedge clk);
        chk("timeout_err", int'(err_flag), 1);
        chk("timeout_q_empty", ev_q.size() + tx_q.size(), 0);
        core_en = 1;
        exp_issue(3, 1);
        send("D");
        drain("drain_after_timeout");

        // Reset while parked in WAIT_TX.
        exp_issue(4, 0);
        send("E");
        for (int k = 0; k < 50; k++) begin
            if (core_valid_in) break;
            @(negedge clk);
        end
        chk("wait_tx_issue_seen", int'(core_valid_in), 1);
        force_busy = 1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_fifo_count", int'(fifo_count), 0);
        chk("midrst_tx_byte", int'(tx_byte), 0);
        chk("midrst_char_in", int'(core_char_in), 0);
        chk("midrst_cfg_pos", int'(core_cfg_pos), 0);
        chk("midrst_err", int'(err_flag), 0);
        chk("midrst_strobes",
            int'({tx_start, core_valid_in, core_cfg_we}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        force_busy = 0;
        repeat (40) @(negedge clk);
        chk("post_rst_fifo", int'(fifo_count), 0);
        chk("final_queues", ev_q.size() + tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
